// File: rtl/ps2_note_decoder_pkg.sv
// Shared constants for the PS/2 note decoder: set-2 scan codes, the
// prefix-tracking FSM state enum, and small note/octave helper functions.
package ps2_synth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_e;

   // Prefix bytes
   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;

   // Note keys, semitone 0..12 in order
   localparam logic [7:0] SC_N0  = 8'h1C;
   localparam logic [7:0] SC_N1  = 8'h1D;
   localparam logic [7:0] SC_N2  = 8'h1B;
   localparam logic [7:0] SC_N3  = 8'h24;
   localparam logic [7:0] SC_N4  = 8'h23;
   localparam logic [7:0] SC_N5  = 8'h2B;
   localparam logic [7:0] SC_N6  = 8'h2C;
   localparam logic [7:0] SC_N7  = 8'h34;
   localparam logic [7:0] SC_N8  = 8'h35;
   localparam logic [7:0] SC_N9  = 8'h33;
   localparam logic [7:0] SC_N10 = 8'h3C;
   localparam logic [7:0] SC_N11 = 8'h3B;
   localparam logic [7:0] SC_N12 = 8'h42;

   // Octave shift keys
   localparam logic [7:0] SC_OCT_DN = 8'h1A;
   localparam logic [7:0] SC_OCT_UP = 8'h22;

   // note number = octave * 12 + semitone; largest value is 7*12+12 = 96
   function automatic logic [6:0] calc_note_num(input logic [2:0] oct,
                                                input logic [3:0] semi);
      return ({4'd0, oct} * 7'd12) + {3'd0, semi};
   endfunction

   // Saturating octave step for the octave shift keys; any other code leaves it alone
   function automatic logic [2:0] octave_step(input logic [2:0] oct,
                                              input logic [7:0] code);
      if ((code == SC_OCT_DN) && (oct != 3'd0)) begin
         return oct - 3'd1;
      end else if ((code == SC_OCT_UP) && (oct != 3'd7)) begin
         return oct + 3'd1;
      end else begin
         return oct;
      end
   endfunction

endpackage

// File: rtl/ps2_note_decoder_if.sv
// Bundle between the PS/2 byte source and the note decoder.
// master: drives scan-code bytes and observes notes; slave: the decoder.
interface ps2_note_decoder_if;
   logic [7:0] ps2_key_data;
   logic       ps2_key_pressed;
   logic       note_on;
   logic       note_off;
   logic       note_active;
   logic [6:0] note_num;

   modport master (
      output ps2_key_data,
      output ps2_key_pressed,
      input  note_on,
      input  note_off,
      input  note_active,
      input  note_num
   );

   modport slave (
      input  ps2_key_data,
      input  ps2_key_pressed,
      output note_on,
      output note_off,
      output note_active,
      output note_num
   );
endinterface

// File: rtl/scancode_to_semitone.sv
// Combinational lookup of a set-2 make code to a semitone 0..12.
// Codes outside the 13 note keys report valid=0.
module scancode_to_semitone
   import ps2_synth_pkg::*;
(
   input  logic [7:0] sc_code,
   output logic [3:0] semitone,
   output logic       valid
);

   // Note key table lookup
   always_comb begin
      semitone = 4'd0;
      valid    = 1'b1;
      case (sc_code)
         SC_N0:   semitone = 4'd0;
         SC_N1:   semitone = 4'd1;
         SC_N2:   semitone = 4'd2;
         SC_N3:   semitone = 4'd3;
         SC_N4:   semitone = 4'd4;
         SC_N5:   semitone = 4'd5;
         SC_N6:   semitone = 4'd6;
         SC_N7:   semitone = 4'd7;
         SC_N8:   semitone = 4'd8;
         SC_N9:   semitone = 4'd9;
         SC_N10:  semitone = 4'd10;
         SC_N11:  semitone = 4'd11;
         SC_N12:  semitone = 4'd12;
         default: begin
            semitone = 4'd0;
            valid    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scan-code to monophonic note decoder.
// Tracks E0/F0 prefixes, keeps one held key, emits registered note_on/note_off
// pulses one cycle after the qualifying strobe. A prefix left dangling for
// TIMEOUT_CYCLES cycles drops the FSM back to IDLE.
// Optional feature: define SCANCODE_OCTAVE_EN to let make 1A/22 shift the
// octave down/up (saturating 0..7); otherwise the octave is DEFAULT_OCTAVE.
module ps2_note_decoder
   import ps2_synth_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int DEFAULT_OCTAVE = 4
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   ps2_note_decoder_if.slave  kbd
);

   localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]     OCT_RST  = DEFAULT_OCTAVE[2:0];

   ps2_state_e       state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic             note_on_r, note_on_nxt_s;
   logic             note_off_r, note_off_nxt_s;
   logic             note_active_r, note_active_nxt_s;
   logic [6:0]       note_num_r, note_num_nxt_s;
   logic [7:0]       held_code_r, held_code_nxt_s;
   logic [2:0]       octave_r, octave_nxt_s;
   logic [3:0]       sem_s;
   logic             sem_valid_s;

   scancode_to_semitone u_s2s (
      .sc_code  (kbd.ps2_key_data),
      .semitone (sem_s),
      .valid    (sem_valid_s)
   );

   // Next-state, timeout and note-event decode; a strobe wins over timeout expiry
   always_comb begin
      state_nxt_s       = state_r;
      cnt_nxt_s         = cnt_r;
      note_on_nxt_s     = 1'b0;
      note_off_nxt_s    = 1'b0;
      note_active_nxt_s = note_active_r;
      note_num_nxt_s    = note_num_r;
      held_code_nxt_s   = held_code_r;
      octave_nxt_s      = octave_r;
      if (kbd.ps2_key_pressed) begin
         cnt_nxt_s = CNT_ZERO;
         case (state_r)
            ST_IDLE: begin
               if (kbd.ps2_key_data == SC_BRK) begin
                  state_nxt_s = ST_BRK;
               end else if (kbd.ps2_key_data == SC_EXT) begin
                  state_nxt_s = ST_EXT;
               end else begin
                  state_nxt_s = ST_IDLE;
                  if (sem_valid_s) begin
                     // A repeat of the held key is typematic and ignored
                     if (!note_active_r || (kbd.ps2_key_data != held_code_r)) begin
                        note_on_nxt_s     = 1'b1;
                        note_active_nxt_s = 1'b1;
                        note_num_nxt_s    = calc_note_num(octave_r, sem_s);
                        held_code_nxt_s   = kbd.ps2_key_data;
                     end else begin
                        note_on_nxt_s = 1'b0;
                     end
                  end else begin
`ifdef SCANCODE_OCTAVE_EN
                     octave_nxt_s = octave_step(octave_r, kbd.ps2_key_data);
`else
                     octave_nxt_s = octave_r;
`endif
                  end
               end
            end
            ST_BRK: begin
               state_nxt_s = ST_IDLE;
               // Only releasing the held key stops the note
               if (note_active_r && (kbd.ps2_key_data == held_code_r)) begin
                  note_off_nxt_s    = 1'b1;
                  note_active_nxt_s = 1'b0;
               end else begin
                  note_off_nxt_s = 1'b0;
               end
            end
            ST_EXT: begin
               if (kbd.ps2_key_data == SC_BRK) begin
                  state_nxt_s = ST_EXT_BRK;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_EXT_BRK: begin
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end else if (state_r != ST_IDLE) begin
         if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
         end
      end else begin
         cnt_nxt_s = CNT_ZERO;
      end
   end

   // FSM state and prefix timeout counter
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Registered note outputs, held key and octave
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         note_on_r     <= 1'b0;
         note_off_r    <= 1'b0;
         note_active_r <= 1'b0;
         note_num_r    <= 7'd0;
         held_code_r   <= 8'h00;
         octave_r      <= OCT_RST;
      end else begin
         note_on_r     <= note_on_nxt_s;
         note_off_r    <= note_off_nxt_s;
         note_active_r <= note_active_nxt_s;
         note_num_r    <= note_num_nxt_s;
         held_code_r   <= held_code_nxt_s;
         octave_r      <= octave_nxt_s;
      end
   end

   assign kbd.note_on     = note_on_r;
   assign kbd.note_off    = note_off_r;
   assign kbd.note_active = note_active_r;
   assign kbd.note_num    = note_num_r;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed self-checking bench for ps2_note_decoder (small TIMEOUT_CYCLES).
// Octave-shift checks depend on SCANCODE_OCTAVE_EN matching the RTL build.
module tb_ps2_note_decoder;

   localparam int TMO = 16;

   logic clk;
   logic rst;
   int   total_cnt;
   int   bad_cnt;
   int   on_cnt;
   int   off_cnt;
   int   both_cnt;
   int   on0;
   int   off0;

   ps2_note_decoder_if bus ();

   ps2_note_decoder #(
      .TIMEOUT_CYCLES (TMO),
      .DEFAULT_OCTAVE (4)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .kbd      (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Pulse counters sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         on_cnt  = on_cnt + int'(bus.note_on);
         off_cnt = off_cnt + int'(bus.note_off);
         if (bus.note_on && bus.note_off) both_cnt = both_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt = total_cnt + 1;
      if (got !== exp) begin
         bad_cnt = bad_cnt + 1;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // One-cycle strobe; returns on the negedge where the registered result shows
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.ps2_key_data    = b;
      bus.ps2_key_pressed = 1'b1;
      @(negedge clk);
      bus.ps2_key_pressed = 1'b0;
      bus.ps2_key_data    = 8'h00;
   endtask

   task automatic snap();
      idle(1);
      on0  = on_cnt;
      off0 = off_cnt;
   endtask

   initial begin
      total_cnt = 0; bad_cnt = 0; on_cnt = 0; off_cnt = 0; both_cnt = 0;
      bus.ps2_key_data    = 8'h00;
      bus.ps2_key_pressed = 1'b0;
      rst = 1'b1;
      idle(3);
      // strobe during reset has no effect
      send_byte(8'h1C);
      check("rst_on",     32'(bus.note_on),     32'd0);
      check("rst_off",    32'(bus.note_off),    32'd0);
      check("rst_active", 32'(bus.note_active), 32'd0);
      check("rst_num",    32'(bus.note_num),    32'd0);
      rst = 1'b0;
      idle(2);

      // first make: C4 = 48
      send_byte(8'h1C);
      check("make_on",     32'(bus.note_on),     32'd1);
      check("make_off",    32'(bus.note_off),    32'd0);
      check("make_num",    32'(bus.note_num),    32'd48);
      check("make_active", 32'(bus.note_active), 32'd1);
      idle(1);
      check("make_on_1cyc", 32'(bus.note_on), 32'd0);

      // break of held key
      snap();
      send_byte(8'hF0);
      send_byte(8'h1C);
      check("brk_off",    32'(bus.note_off),    32'd1);
      check("brk_active", 32'(bus.note_active), 32'd0);
      check("brk_num",    32'(bus.note_num),    32'd48);
      idle(1);
      check("brk_off_cnt", 32'(off_cnt - off0), 32'd1);
      check("brk_on_cnt",  32'(on_cnt - on0),   32'd0);

      // typematic repeat then new key
      send_byte(8'h1C);
      snap();
      for (int i = 0; i < 3; i++) send_byte(8'h1C);
      send_byte(8'h1D);
      idle(1);
      check("rpt_on_cnt",  32'(on_cnt - on0),   32'd1);
      check("rpt_off_cnt", 32'(off_cnt - off0), 32'd0);
      check("rpt_num",     32'(bus.note_num),   32'd49);

      // break of non-held key, extended break, extended make, unmapped make
      snap();
      send_byte(8'hF0); send_byte(8'h1C);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1D);
      send_byte(8'hE0); send_byte(8'h1C);
      send_byte(8'h15);
      idle(1);
      check("ign_on_cnt",  32'(on_cnt - on0),     32'd0);
      check("ign_off_cnt", 32'(off_cnt - off0),   32'd0);
      check("ign_active",  32'(bus.note_active),  32'd1);
      check("ign_num",     32'(bus.note_num),     32'd49);

      // release 1D, then F0 left dangling for TMO cycles
      send_byte(8'hF0); send_byte(8'h1D);
      check("rel_active", 32'(bus.note_active), 32'd0);
      send_byte(8'hF0);
      idle(TMO - 1);
      send_byte(8'h1C);
      check("tmo_on",  32'(bus.note_on),  32'd1);
      check("tmo_num", 32'(bus.note_num), 32'd48);

      // strobe on the exact expiry cycle is still a break
      send_byte(8'hF0);
      idle(TMO - 2);
      send_byte(8'h1C);
      check("tmo_edge_off",    32'(bus.note_off),    32'd1);
      check("tmo_edge_active", 32'(bus.note_active), 32'd0);
      send_byte(8'h1C);
      check("remake_on", 32'(bus.note_on), 32'd1);

`ifdef SCANCODE_OCTAVE_EN
      snap();
      for (int i = 0; i < 5; i++) send_byte(8'h22);
      idle(1);
      check("octup_on_cnt", 32'(on_cnt - on0), 32'd0);
      send_byte(8'h42);
      check("oct7_num", 32'(bus.note_num), 32'd96);
      for (int i = 0; i < 9; i++) send_byte(8'h1A);
      check("octdn_num_kept", 32'(bus.note_num), 32'd96);
      send_byte(8'h1C);
      check("oct0_on",  32'(bus.note_on),  32'd1);
      check("oct0_num", 32'(bus.note_num), 32'd0);
`else
      snap();
      send_byte(8'h22);
      send_byte(8'h1A);
      idle(1);
      check("oct_dis_on_cnt", 32'(on_cnt - on0), 32'd0);
      send_byte(8'h42);
      check("oct_dis_num", 32'(bus.note_num), 32'd60);
`endif

      // asynchronous reset mid-note
      check("pre_rst_active", 32'(bus.note_active), 32'd1);
      snap();
      rst = 1'b1;
      #1;
      check("arst_active", 32'(bus.note_active), 32'd0);
      check("arst_num",    32'(bus.note_num),    32'd0);
      check("arst_off",    32'(bus.note_off),    32'd0);
      idle(2);
      rst = 1'b0;
      idle(3);
      check("arst_off_cnt", 32'(off_cnt - off0), 32'd0);
      check("arst_on_cnt",  32'(on_cnt - on0),   32'd0);
      check("never_both",   32'(both_cnt),       32'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/ps2_note_decoder.md
PS2_NOTE_DECODER -- requirements
Module: ps2_note_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, max cycles allowed between a prefix byte (E0/F0) and its follow-on byte.
REQ-002 SHALL have parameter DEFAULT_OCTAVE, default 4, octave loaded at reset (range 0..7).
REQ-003 SHALL have port CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port ps2_key_data  in  8  scan-code byte from the PS/2 controller, valid only while ps2_key_pressed=1.
REQ-006 SHALL have port ps2_key_pressed  in  1  one-cycle strobe qualifying ps2_key_data.
REQ-007 SHALL have port note_on  out  1  one-cycle pulse, a new note starts.
REQ-008 SHALL have port note_off  out  1  one-cycle pulse, the sounding note stops.
REQ-009 SHALL have port note_active  out  1  level, a mapped key is held.
REQ-010 SHALL have port note_num  out  7  octave*12+semitone, held stable between note_on pulses.

Function
REQ-011 SHALL run the FSM IDLE, BRK (after F0), EXT (after E0) and EXT_BRK (after E0 then F0).
REQ-012 SHALL make these transitions on a strobe: IDLE: F0->BRK, E0->EXT, other->IDLE (make). BRK: any->IDLE (break). EXT: F0->EXT_BRK, other->IDLE (discard). EXT_BRK: any->IDLE (discard).
REQ-013 SHALL map set-2 make codes 1C,1D,1B,24,23,2B,2C,34,35,33,3C,3B,42 to semitones 0..12, and ignore unmapped codes.
REQ-014 SHALL, on a mapped make in IDLE when the key differs from the held key or no key is held: load note_num, set note_active, and pulse note_on once; note_off is not pulsed.
REQ-015 SHALL ignore a make of the already-held key (typematic repeat): no pulse, no change.
REQ-016 SHALL, on a break of the held key: clear note_active and pulse note_off; note_num keeps its value.
REQ-017 SHALL ignore breaks of non-held or unmapped keys.
REQ-018 SHALL assert outputs on the cycle after the strobe (one-cycle registered latency).
REQ-019 SHALL run a timeout counter in any non-IDLE state; reaching TIMEOUT_CYCLES returns the FSM to IDLE with no output effect.
REQ-020 SHALL give a strobe priority when it coincides with timeout expiry; the byte is processed in the current state.
REQ-021 SHALL never pulse note_on and note_off in the same cycle.

Reset
REQ-022 SHALL, while reset=1, immediately force: state=IDLE, timeout counter=0, note_on=0, note_off=0, note_active=0, note_num=0, held key cleared, octave=DEFAULT_OCTAVE.
REQ-023 SHALL dominate all strobes, and SHALL produce no note_off when asserted mid-note.

Configuration
REQ-024 SHALL, with SCANCODE_OCTAVE_EN defined, treat make 1A as octave-1 and make 22 as octave+1, saturating at 0 and 7, with no note pulses; the new octave applies at the next note_on only.
REQ-025 SHALL, without SCANCODE_OCTAVE_EN, fix the octave at DEFAULT_OCTAVE and treat 1A and 22 as unmapped.

Structure
REQ-026 SHALL take scan-code constants (E0, F0, 13 note codes, 1A, 22) and the FSM state enum from shared package ps2_synth_pkg.
REQ-027 SHALL instantiate combinational sub-module scancode_to_semitone: 8-bit code in, 4-bit semitone and valid out.

Verification
REQ-028 SHALL cover reset release, then strobe 1C -> note_on pulse at +1 cycle, note_num=48, note_active=1.
REQ-029 SHALL cover 1C held, then strobes F0,1C -> single note_off pulse, note_active=0, note_num stays 48.
REQ-030 SHALL cover 1C held, then 1C repeated x3, then 1D -> exactly one further note_on, note_num=49.
REQ-031 SHALL cover E0,F0,1C while 1C held -> no pulses, note_active stays 1; and F0 followed by TIMEOUT_CYCLES idle cycles -> FSM back to IDLE, then 1C -> note_on.
REQ-032 SHALL cover, with SCANCODE_OCTAVE_EN: 22 x5, then 42 -> note_num=96 (octave saturated at 7); 1A x9, then 1C -> note_num=0.
REQ-033 SHALL cover reset asserted while note_active=1 -> all outputs 0 asynchronously, no note_off pulse.
